// File: rtl/dm_responder.sv
// Data-memory responder: one load/store in flight, LATENCY wait states, valid/ready response.
// Optional alignment/byte-enable checking is enabled by defining MISALIGN_CHECK_EN.
module dm_responder #(
    parameter int          ADDR_WIDTH = 12,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  count;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;
    logic [31:0] mem [DEPTH];

    logic                  acc_we;
    logic [31:0]           acc_addr;
    logic [31:0]           acc_wdata;
    logic [3:0]            acc_be;
    logic [31:0]           offset;
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           old_word;
    logic [31:0]           new_word;
    logic                  acc_err;
    logic                  accept;
    logic                  do_access;

    // With zero latency the access happens on the accept edge, so it must see the live request.
    always_comb begin
        acc_we    = lat_we;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        acc_be    = lat_be;
        if (state == IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end
        offset   = acc_addr - BASE_ADDR;
        idx      = offset[ADDR_WIDTH+1:2];
        old_word = mem[idx];
        new_word = old_word;
        for (int k = 0; k < 4; k++) begin
            if (acc_be[k]) begin
                new_word[8*k +: 8] = acc_wdata[8*k +: 8];
            end
        end
    end

    logic unused_offset_bits;
    assign unused_offset_bits = ^{offset[31:ADDR_WIDTH+2], offset[1:0]};

`ifdef MISALIGN_CHECK_EN
    logic be_single;
    logic be_half;
    logic be_full;

    always_comb begin
        be_single = (acc_be == 4'b0001) || (acc_be == 4'b0010) ||
                    (acc_be == 4'b0100) || (acc_be == 4'b1000);
        be_half   = (acc_be == 4'b0011) || (acc_be == 4'b1100);
        be_full   = (acc_be == 4'b1111);
        acc_err   = 1'b0;
        if (acc_we) begin
            if (be_full && (acc_addr[1:0] != 2'b00)) acc_err = 1'b1;
            if (be_half && acc_addr[0])              acc_err = 1'b1;
            if (!(be_single || be_half || be_full))  acc_err = 1'b1;
        end else if (acc_addr[1:0] != 2'b00) begin
            acc_err = 1'b1;
        end
    end
`else
    assign acc_err = 1'b0;
`endif

    assign accept    = (state == IDLE) && req_valid && req_ready;
    assign do_access = (accept && (LATENCY == 0)) || ((state == WAIT) && (count == 4'd0));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            count      <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_be     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_be    <= req_be;
                        req_ready <= 1'b0;
                        if (LATENCY != 0) begin
                            count <= WAIT_LOAD;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase

            // Erroneous requests never write and report a zero data word.
            if (do_access) begin
                if (acc_we && !acc_err) begin
                    mem[idx] <= new_word;
                end
                resp_rdata <= acc_err ? 32'h0 : (acc_we ? new_word : old_word);
                resp_err   <= acc_err;
                resp_valid <= 1'b1;
                state      <= RESP;
            end
        end
    end

endmodule
